// File: rtl/alu_control_seq.sv
// alu_control_seq: registered MIPS ALU control unit (ALUOp/funct -> ALUOperation).
// Optional feature macro ALU_CTRL_MULDIV_EN: when defined, MULT/MULTU/DIV/DIVU decode
// to MUL/DIV and an IDLE/BUSY sequencer stalls the pipeline for MDU_CYCLES cycles.
// When undefined, those functs decode as illegal and all MDU outputs are tied low.
module alu_control_seq #(
   parameter int unsigned OP_WIDTH    = 3,
   parameter int unsigned FUNCT_WIDTH = 6,
   parameter int unsigned OPER_WIDTH  = 4,
   parameter int unsigned MDU_CYCLES  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [OP_WIDTH-1:0]    ALUOp,
   input  logic [FUNCT_WIDTH-1:0] ALUFunction,
   output logic [OPER_WIDTH-1:0]  ALUOperation,
   output logic                   op_valid,
   output logic                   illegal,
   output logic                   stall,
   output logic                   md_start,
   output logic                   md_div,
   output logic                   md_signed,
   output logic                   md_done
);

   // Elaboration-time parameter sanity checks.
   generate
      if (OPER_WIDTH < 4) begin : g_bad_oper_width
         $error("OPER_WIDTH must be at least 4");
      end
      if (MDU_CYCLES < 1) begin : g_bad_mdu_cycles
         $error("MDU_CYCLES must be at least 1");
      end
   endgenerate

   localparam logic [OPER_WIDTH-1:0] C_AND = OPER_WIDTH'(4'b0000);
   localparam logic [OPER_WIDTH-1:0] C_OR  = OPER_WIDTH'(4'b0001);
   localparam logic [OPER_WIDTH-1:0] C_NOR = OPER_WIDTH'(4'b0010);
   localparam logic [OPER_WIDTH-1:0] C_ADD = OPER_WIDTH'(4'b0011);
   localparam logic [OPER_WIDTH-1:0] C_SUB = OPER_WIDTH'(4'b0100);
   localparam logic [OPER_WIDTH-1:0] C_SLT = OPER_WIDTH'(4'b0101);
   localparam logic [OPER_WIDTH-1:0] C_SLL = OPER_WIDTH'(4'b0110);
   localparam logic [OPER_WIDTH-1:0] C_SRL = OPER_WIDTH'(4'b0111);
   localparam logic [OPER_WIDTH-1:0] C_LUI = OPER_WIDTH'(4'b1000);
   localparam logic [OPER_WIDTH-1:0] C_NOP = OPER_WIDTH'(4'b1001);
`ifdef ALU_CTRL_MULDIV_EN
   localparam logic [OPER_WIDTH-1:0] C_MUL = OPER_WIDTH'(4'b1010);
   localparam logic [OPER_WIDTH-1:0] C_DIV = OPER_WIDTH'(4'b1011);
`endif

   logic [OPER_WIDTH-1:0] dec_code;
   logic                  dec_illegal;
`ifdef ALU_CTRL_MULDIV_EN
   logic                  dec_md;
   logic                  dec_div;
   logic                  dec_signed;
`endif

   // Combinational decode of the presented ALUOp/funct pair.
   always_comb begin
      dec_code    = C_NOP;
      dec_illegal = 1'b1;
`ifdef ALU_CTRL_MULDIV_EN
      dec_md      = 1'b0;
      dec_div     = 1'b0;
      dec_signed  = 1'b0;
`endif
      case (ALUOp)
         OP_WIDTH'(3'b000): begin dec_code = C_ADD; dec_illegal = 1'b0; end
         OP_WIDTH'(3'b001): begin dec_code = C_SUB; dec_illegal = 1'b0; end
         OP_WIDTH'(3'b010): begin dec_code = C_LUI; dec_illegal = 1'b0; end
         OP_WIDTH'(3'b011): begin dec_code = C_SLT; dec_illegal = 1'b0; end
         OP_WIDTH'(3'b100): begin dec_code = C_ADD; dec_illegal = 1'b0; end
         OP_WIDTH'(3'b101): begin dec_code = C_OR;  dec_illegal = 1'b0; end
         OP_WIDTH'(3'b110): begin dec_code = C_AND; dec_illegal = 1'b0; end
         OP_WIDTH'(3'b111): begin
            case (ALUFunction)
               FUNCT_WIDTH'(6'b100100): begin dec_code = C_AND; dec_illegal = 1'b0; end
               FUNCT_WIDTH'(6'b100101): begin dec_code = C_OR;  dec_illegal = 1'b0; end
               FUNCT_WIDTH'(6'b100111): begin dec_code = C_NOR; dec_illegal = 1'b0; end
               FUNCT_WIDTH'(6'b100000): begin dec_code = C_ADD; dec_illegal = 1'b0; end
               FUNCT_WIDTH'(6'b100010): begin dec_code = C_SUB; dec_illegal = 1'b0; end
               FUNCT_WIDTH'(6'b101010): begin dec_code = C_SLT; dec_illegal = 1'b0; end
               FUNCT_WIDTH'(6'b000000): begin dec_code = C_SLL; dec_illegal = 1'b0; end
               FUNCT_WIDTH'(6'b000010): begin dec_code = C_SRL; dec_illegal = 1'b0; end
`ifdef ALU_CTRL_MULDIV_EN
               FUNCT_WIDTH'(6'b011000): begin
                  dec_code = C_MUL; dec_illegal = 1'b0; dec_md = 1'b1; dec_signed = 1'b1;
               end
               FUNCT_WIDTH'(6'b011001): begin
                  dec_code = C_MUL; dec_illegal = 1'b0; dec_md = 1'b1;
               end
               FUNCT_WIDTH'(6'b011010): begin
                  dec_code = C_DIV; dec_illegal = 1'b0; dec_md = 1'b1;
                  dec_div = 1'b1; dec_signed = 1'b1;
               end
               FUNCT_WIDTH'(6'b011011): begin
                  dec_code = C_DIV; dec_illegal = 1'b0; dec_md = 1'b1; dec_div = 1'b1;
               end
`endif
               default: begin dec_code = C_NOP; dec_illegal = 1'b1; end
            endcase
         end
         default: begin dec_code = C_NOP; dec_illegal = 1'b1; end
      endcase
   end

`ifdef ALU_CTRL_MULDIV_EN
   localparam int unsigned CNT_W = $clog2(MDU_CYCLES) + 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;

   // Accept in IDLE, hold off the pipeline for MDU_CYCLES cycles on mul/div.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         count        <= '0;
         ALUOperation <= C_NOP;
         op_valid     <= 1'b0;
         illegal      <= 1'b0;
         stall        <= 1'b0;
         md_start     <= 1'b0;
         md_div       <= 1'b0;
         md_signed    <= 1'b0;
         md_done      <= 1'b0;
      end else begin
         op_valid <= 1'b0;
         md_start <= 1'b0;
         md_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ALUOperation <= dec_code;
                  op_valid     <= 1'b1;
                  illegal      <= dec_illegal;
                  if (dec_md) begin
                     md_start  <= 1'b1;
                     md_div    <= dec_div;
                     md_signed <= dec_signed;
                     stall     <= 1'b1;
                     count     <= CNT_W'(MDU_CYCLES - 1);
                     state     <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (count == '0) begin
                  state   <= IDLE;
                  stall   <= 1'b0;
                  md_done <= 1'b1;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   // Register the decode of every accepted instruction; no MDU sequencing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ALUOperation <= C_NOP;
         op_valid     <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         op_valid <= in_valid;
         if (in_valid) begin
            ALUOperation <= dec_code;
            illegal      <= dec_illegal;
         end
      end
   end

   assign stall     = 1'b0;
   assign md_start  = 1'b0;
   assign md_div    = 1'b0;
   assign md_signed = 1'b0;
   assign md_done   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: directed self-checking bench for alu_control_seq.
// Two instances share stimulus: dut4 (MDU_CYCLES=4) and dut1 (MDU_CYCLES=1).
module tb_alu_control_seq;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [2:0] ALUOp;
   logic [5:0] ALUFunction;

   logic [3:0] oper4, oper1;
   logic       opv4, ill4, stall4, mds4, mdd4, mdsg4, done4;
   logic       opv1, ill1, stall1, mds1, mdd1, mdsg1, done1;

   int checks = 0;
   int errors = 0;

   alu_control_seq #(.OP_WIDTH(3), .FUNCT_WIDTH(6), .OPER_WIDTH(4), .MDU_CYCLES(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .ALUOp(ALUOp), .ALUFunction(ALUFunction),
      .ALUOperation(oper4), .op_valid(opv4), .illegal(ill4), .stall(stall4),
      .md_start(mds4), .md_div(mdd4), .md_signed(mdsg4), .md_done(done4));

   alu_control_seq #(.OP_WIDTH(3), .FUNCT_WIDTH(6), .OPER_WIDTH(4), .MDU_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .ALUOp(ALUOp), .ALUFunction(ALUFunction),
      .ALUOperation(oper1), .op_valid(opv1), .illegal(ill1), .stall(stall1),
      .md_start(mds1), .md_div(mdd1), .md_signed(mdsg1), .md_done(done1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn);
      in_valid    = v;
      ALUOp       = op;
      ALUFunction = fn;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 3'b000, 6'b000000);
      tick();
      tick();
      checks++; if (oper4 !== 4'b1001) begin errors++; $display("FAIL reset_oper got %b exp 1001", oper4); end
      checks++; if (oper1 !== 4'b1001) begin errors++; $display("FAIL reset_oper1 got %b exp 1001", oper1); end
      checks++; if ({opv4, ill4, stall4, mds4, mdd4, mdsg4, done4} !== 7'b0)
         begin errors++; $display("FAIL reset_flags got %b exp 0000000", {opv4, ill4, stall4, mds4, mdd4, mdsg4, done4}); end
      reset = 1'b0;
      tick();
      checks++; if (opv4 !== 1'b0) begin errors++; $display("FAIL idle_opv got %b exp 0", opv4); end
   endtask

   task automatic test_rtype();
      logic [5:0] fn  [8];
      logic [3:0] exp [8];
      fn  = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b101010, 6'b000000, 6'b000010};
      exp = '{4'b0000,   4'b0001,   4'b0010,   4'b0011,   4'b0100,   4'b0101,   4'b0110,   4'b0111};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'b111, fn[i]);
         tick();
         checks++; if (oper4 !== exp[i]) begin errors++; $display("FAIL rtype_oper[%0d] got %b exp %b", i, oper4, exp[i]); end
         checks++; if (opv4 !== 1'b1 || ill4 !== 1'b0) begin errors++; $display("FAIL rtype_flags[%0d] got opv=%b ill=%b exp opv=1 ill=0", i, opv4, ill4); end
         checks++; if (stall4 !== 1'b0 || mds4 !== 1'b0) begin errors++; $display("FAIL rtype_stall[%0d] got stall=%b md_start=%b exp 0 0", i, stall4, mds4); end
      end
   endtask

   task automatic test_iclass();
      logic [3:0] exp [7];
      exp = '{4'b0011, 4'b0100, 4'b1000, 4'b0101, 4'b0011, 4'b0001, 4'b0000};
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 3'(i), 6'($urandom_range(0, 63)));
         tick();
         checks++; if (oper4 !== exp[i]) begin errors++; $display("FAIL iclass_oper[%0d] got %b exp %b", i, oper4, exp[i]); end
         checks++; if (opv4 !== 1'b1 || ill4 !== 1'b0) begin errors++; $display("FAIL iclass_flags[%0d] got opv=%b ill=%b exp opv=1 ill=0", i, opv4, ill4); end
      end
      drive(1'b1, 3'b111, 6'b111111);
      tick();
      checks++; if (oper4 !== 4'b1001) begin errors++; $display("FAIL illegal_oper got %b exp 1001", oper4); end
      checks++; if (ill4 !== 1'b1 || opv4 !== 1'b1) begin errors++; $display("FAIL illegal_flag got ill=%b opv=%b exp 1 1", ill4, opv4); end
      drive(1'b1, 3'b000, 6'b111111);
      tick();
      checks++; if (ill4 !== 1'b0 || oper4 !== 4'b0011) begin errors++; $display("FAIL illegal_clear got ill=%b oper=%b exp 0 0011", ill4, oper4); end
   endtask

   task automatic test_hold();
      drive(1'b1, 3'b101, 6'b000000);
      tick();
      drive(1'b0, 3'b001, 6'b100111);
      tick();
      checks++; if (opv4 !== 1'b0) begin errors++; $display("FAIL hold_opv got %b exp 0", opv4); end
      tick();
      checks++; if (oper4 !== 4'b0001) begin errors++; $display("FAIL hold_oper got %b exp 0001", oper4); end
      checks++; if (opv4 !== 1'b0) begin errors++; $display("FAIL hold_opv2 got %b exp 0", opv4); end
   endtask

`ifdef ALU_CTRL_MULDIV_EN
   task automatic test_div_stall();
      drive(1'b1, 3'b111, 6'b011010);
      tick();  // edge T
      checks++; if (oper4 !== 4'b1011 || opv4 !== 1'b1 || ill4 !== 1'b0)
         begin errors++; $display("FAIL div_accept got oper=%b opv=%b ill=%b exp 1011 1 0", oper4, opv4, ill4); end
      checks++; if ({mds4, mdd4, mdsg4, stall4, done4} !== 5'b11110)
         begin errors++; $display("FAIL div_start got %b exp 11110", {mds4, mdd4, mdsg4, stall4, done4}); end
      drive(1'b1, 3'b111, 6'b100100);  // held AND while stalled
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if ({stall4, opv4, mds4, done4} !== 4'b1000)
            begin errors++; $display("FAIL div_busy[%0d] got stall,opv,start,done=%b exp 1000", k, {stall4, opv4, mds4, done4}); end
         checks++; if (oper4 !== 4'b1011) begin errors++; $display("FAIL div_busy_oper[%0d] got %b exp 1011", k, oper4); end
      end
      tick();  // edge T+4
      checks++; if ({stall4, done4, opv4} !== 3'b010)
         begin errors++; $display("FAIL div_done got stall,done,opv=%b exp 010", {stall4, done4, opv4}); end
      checks++; if (oper4 !== 4'b1011 || mdd4 !== 1'b1 || mdsg4 !== 1'b1)
         begin errors++; $display("FAIL div_done_hold got oper=%b div=%b sgn=%b exp 1011 1 1", oper4, mdd4, mdsg4); end
      tick();  // edge T+5
      checks++; if (oper4 !== 4'b0000 || opv4 !== 1'b1 || done4 !== 1'b0 || stall4 !== 1'b0)
         begin errors++; $display("FAIL div_next got oper=%b opv=%b done=%b stall=%b exp 0000 1 0 0", oper4, opv4, done4, stall4); end
   endtask

   task automatic test_multu();
      drive(1'b1, 3'b111, 6'b011001);
      tick();
      checks++; if (oper4 !== 4'b1010 || {mds4, mdd4, mdsg4, stall4} !== 4'b1001)
         begin errors++; $display("FAIL multu_start got oper=%b start,div,sgn,stall=%b exp 1010 1001", oper4, {mds4, mdd4, mdsg4, stall4}); end
      drive(1'b0, 3'b000, 6'b000000);
      for (int k = 1; k <= 4; k++) tick();
      checks++; if (done4 !== 1'b1 || stall4 !== 1'b0 || mdd4 !== 1'b0 || mdsg4 !== 1'b0)
         begin errors++; $display("FAIL multu_done got done=%b stall=%b div=%b sgn=%b exp 1 0 0 0", done4, stall4, mdd4, mdsg4); end
      tick();
      checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b exp 0", done4); end
   endtask

   task automatic test_mdu1();
      drive(1'b1, 3'b111, 6'b011000);
      tick();  // edge T
      checks++; if (oper1 !== 4'b1010 || {mds1, mdd1, mdsg1, stall1, done1} !== 5'b10110)
         begin errors++; $display("FAIL mdu1_start got oper=%b start,div,sgn,stall,done=%b exp 1010 10110", oper1, {mds1, mdd1, mdsg1, stall1, done1}); end
      drive(1'b1, 3'b000, 6'b000000);
      tick();  // edge T+1
      checks++; if ({stall1, done1, mds1, opv1} !== 4'b0100)
         begin errors++; $display("FAIL mdu1_done got stall,done,start,opv=%b exp 0100", {stall1, done1, mds1, opv1}); end
      tick();  // edge T+2
      checks++; if (oper1 !== 4'b0011 || opv1 !== 1'b1 || done1 !== 1'b0)
         begin errors++; $display("FAIL mdu1_next got oper=%b opv=%b done=%b exp 0011 1 0", oper1, opv1, done1); end
      drive(1'b0, 3'b000, 6'b000000);
   endtask
`else
   task automatic test_muldiv_disabled();
      logic [5:0] fn [4];
      fn = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 3'b111, fn[i]);
         tick();
         checks++; if (oper4 !== 4'b1001 || ill4 !== 1'b1 || opv4 !== 1'b1)
            begin errors++; $display("FAIL md_off_decode[%0d] got oper=%b ill=%b opv=%b exp 1001 1 1", i, oper4, ill4, opv4); end
         checks++; if ({stall4, mds4, mdd4, mdsg4, done4} !== 5'b0)
            begin errors++; $display("FAIL md_off_outs[%0d] got %b exp 00000", i, {stall4, mds4, mdd4, mdsg4, done4}); end
      end
      drive(1'b1, 3'b111, 6'b100010);
      tick();
      checks++; if (oper4 !== 4'b0100 || ill4 !== 1'b0 || stall4 !== 1'b0)
         begin errors++; $display("FAIL md_off_after got oper=%b ill=%b stall=%b exp 0100 0 0", oper4, ill4, stall4); end
   endtask
`endif

   task automatic test_reset_midop();
`ifdef ALU_CTRL_MULDIV_EN
      drive(1'b1, 3'b111, 6'b011010);
`else
      drive(1'b1, 3'b111, 6'b100000);
`endif
      tick();
      drive(1'b0, 3'b000, 6'b000000);
      tick();
      tick();
`ifdef ALU_CTRL_MULDIV_EN
      checks++; if (stall4 !== 1'b1) begin errors++; $display("FAIL busy_before_reset got stall=%b exp 1", stall4); end
`endif
      #2 reset = 1'b1;
      #1;
      checks++; if (oper4 !== 4'b1001) begin errors++; $display("FAIL async_reset_oper got %b exp 1001", oper4); end
      checks++; if ({opv4, ill4, stall4, mds4, mdd4, mdsg4, done4} !== 7'b0)
         begin errors++; $display("FAIL async_reset_flags got %b exp 0000000", {opv4, ill4, stall4, mds4, mdd4, mdsg4, done4}); end
      tick();
      reset = 1'b0;
      drive(1'b1, 3'b111, 6'b100000);
      tick();
      checks++; if (oper4 !== 4'b0011 || opv4 !== 1'b1 || stall4 !== 1'b0)
         begin errors++; $display("FAIL post_reset_add got oper=%b opv=%b stall=%b exp 0011 1 0", oper4, opv4, stall4); end
      drive(1'b0, 3'b000, 6'b000000);
      tick();
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_iclass();
      test_hold();
`ifdef ALU_CTRL_MULDIV_EN
      test_div_stall();
      drive(1'b0, 3'b000, 6'b000000);
      tick();
      test_multu();
      test_mdu1();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
`else
      test_muldiv_disabled();
`endif
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, parametrised ALU control unit for the MIPS datapath, sitting between the main control decoder and the ALU/multiply-divide unit (MDU). It decodes ALUOp and funct into a registered ALU operation code. It adds SLT/ANDI/LUI/SLTI and multiply/divide decoding. It also sequences multi-cycle MULT/MULTU/DIV/DIVU operations with a stall handshake toward the pipeline.

## Interface
- OP_WIDTH, 3, ALUOp width
- FUNCT_WIDTH, 6, funct field width
- OPER_WIDTH, 4, ALUOperation width (≥4)
- MDU_CYCLES, 32, cycles a mul/div occupies the MDU (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  ALUOp/ALUFunction valid this cycle
- ALUOp  in  OP_WIDTH  main-control operation class
- ALUFunction  in  FUNCT_WIDTH  instruction funct field
- ALUOperation  out  OPER_WIDTH  registered ALU operation code
- op_valid  out  1  one-cycle pulse: ALUOperation updated for accepted instruction
- illegal  out  1  registered with op_valid: accepted encoding unrecognised
- stall  out  1  MDU busy; upstream must hold instruction and in_valid
- md_start  out  1  one-cycle MDU start pulse
- md_div  out  1  valid with md_start: 1 = divide, 0 = multiply
- md_signed  out  1  valid with md_start: 1 = signed (MULT/DIV)
- md_done  out  1  one-cycle pulse on the last busy cycle's exit

## Operation
- Codes: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, SLT 0101, SLL 0110, SRL 0111, LUI 1000, NOP/illegal 1001, MUL 1010, DIV 1011; zero-extended to OPER_WIDTH.
- ALUOp 111 (R-type) by funct: 100100 AND, 100101 OR, 100111 NOR, 100000 ADD, 100010 SUB, 101010 SLT, 000000 SLL, 000010 SRL, 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
- ALUOp, funct ignored: 000 ADD (LW/SW), 001 SUB (BEQ/BNE), 010 LUI, 011 SLT (SLTI), 100 ADD (ADDI), 101 OR (ORI), 110 AND (ANDI).
- Any other combination: ALUOperation=1001, illegal=1.
- FSM states IDLE, BUSY. Reset state IDLE.
- IDLE, in_valid=1 at edge: register code, op_valid=1, illegal per decode. If mul/div: md_start=1, md_div/md_signed set, state→BUSY, counter=MDU_CYCLES-1, stall=1.
- IDLE, in_valid=0: op_valid=0, ALUOperation holds.
- BUSY: in_valid, ALUOp and ALUFunction are ignored. Counter decrements each edge. At an edge with counter==0: state→IDLE, stall=0, md_done=1.
- md_div/md_signed hold their values until the next md_start.
- Counter width: $clog2(MDU_CYCLES)+1 bits; no wrap is possible.
- Reset asserted in any state, including mid-BUSY: immediate return to IDLE. Outputs: ALUOperation=1001, all 1-bit outputs 0, counter 0.

## Timing
- Latency 1: decode of an instruction accepted at edge T is visible after T. An accepted instruction is one where in_valid=1 at T in IDLE.
- stall rises after the accepting edge T and is high for exactly MDU_CYCLES cycles. It falls after edge T+MDU_CYCLES, coincident with md_done=1 for one cycle.
- The first new instruction can be accepted at edge T+MDU_CYCLES+1.
- Non-mul/div instructions accept back-to-back, one per cycle, with stall never asserted.
- MDU_CYCLES=1: stall high one cycle; md_start and stall coincide; md_done follows the next cycle.
- op_valid, md_start and md_done never exceed one cycle in length.

## Configuration
- ALU_CTRL_MULDIV_EN defined: MULT/MULTU/DIV/DIVU decode to MUL/DIV and the BUSY sequencing above applies.
- ALU_CTRL_MULDIV_EN undefined: the FSM and counter are not built. Those four functs decode as illegal (1001, illegal=1). stall, md_start, md_div, md_signed and md_done are tied to 0.

## Test plan
- Reset then apply ALUOp=111 with funct 100100/100101/100111/100000/100010/101010/000000/000010, one per cycle. Expect ALUOperation 0000/0001/0010/0011/0100/0101/0110/0111 one cycle later, op_valid=1 each cycle, stall=0.
- Apply I-class ALUOp 000–110 with random funct. Expect 0011, 0100, 1000, 0101, 0011, 0001, 0000. ALUOp=111 with funct 111111 → 1001, illegal=1.
- Run with MDU_CYCLES=4. Issue DIV (111/011010) at edge T. Expect md_start=1, md_div=1, md_signed=1 after T, and stall=1 for 4 cycles. Hold a differing in_valid instruction during stall: it is ignored, ALUOperation stays 1011. md_done=1 and stall=0 after T+4; the held instruction is accepted at T+5.
- Issue MULTU. Expect ALUOperation=1010, md_div=0, md_signed=0. Run again with MDU_CYCLES=1 to check the edge-case timing.
- Assert reset two cycles into BUSY. Expect immediate stall=0, ALUOperation=1001, all pulses 0. After release, an ADD is accepted on the first in_valid edge.
- Build without ALU_CTRL_MULDIV_EN and issue MULT. Expect ALUOperation=1001, illegal=1, stall and md_start never asserted.
